// File: rtl/pe_conv1d_mac.sv
// Row-stationary 1-D convolution MAC for the processing element.
// Reads filter taps and ifmap windows from the scratch pads and streams one partial sum per output index.
module pe_conv1d_mac #(
    parameter int DATA_WIDTH = 16,
    parameter int PSUM_WIDTH = 32,
    parameter int FILT_LEN   = 3,
    parameter int IFMAP_LEN  = 9,
    localparam int OUT_LEN   = IFMAP_LEN - FILT_LEN + 1,
    localparam int FA_W      = (FILT_LEN  > 1) ? $clog2(FILT_LEN)  : 1,
    localparam int IA_W      = (IFMAP_LEN > 1) ? $clog2(IFMAP_LEN) : 1,
    localparam int OI_W      = (OUT_LEN   > 1) ? $clog2(OUT_LEN)   : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [FA_W-1:0]       f_raddr,
    input  logic [DATA_WIDTH-1:0] f_rdata,
    output logic [IA_W-1:0]       i_raddr,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [PSUM_WIDTH-1:0] o_data,
    output logic [OI_W-1:0]       o_idx
);

    localparam logic [FA_W-1:0] S_ZERO = FA_W'(0);
    localparam logic [FA_W-1:0] S_ONE  = FA_W'(1);
    localparam logic [FA_W-1:0] S_LAST = FA_W'(FILT_LEN - 1);
    localparam logic [OI_W-1:0] E_ZERO = OI_W'(0);
    localparam logic [OI_W-1:0] E_ONE  = OI_W'(1);
    localparam logic [OI_W-1:0] E_LAST = OI_W'(OUT_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t                         state_r, state_s;
    logic [FA_W-1:0]                s_r, s_s;
    logic [OI_W-1:0]                e_r, e_s;
    logic signed [2*DATA_WIDTH-1:0] prod_r, prod_s;
    logic signed [PSUM_WIDTH-1:0]   acc_r, acc_s;
    logic                           busy_r, busy_s;
    logic                           done_r, done_s;
    logic                           o_valid_r, o_valid_s;
    logic [PSUM_WIDTH-1:0]          o_data_r, o_data_s;
    logic [OI_W-1:0]                o_idx_r, o_idx_s;
    logic [FA_W-1:0]                f_raddr_r, f_raddr_s;
    logic [IA_W-1:0]                i_raddr_r, i_raddr_s;

    // Operands are sign-extended first so the product is exact at 2*DATA_WIDTH bits.
    logic signed [2*DATA_WIDTH-1:0] f_ext_s, i_ext_s, mult_s;
    logic signed [PSUM_WIDTH-1:0]   prod_ext_s;

    assign f_ext_s    = {{DATA_WIDTH{f_rdata[DATA_WIDTH-1]}}, f_rdata};
    assign i_ext_s    = {{DATA_WIDTH{i_rdata[DATA_WIDTH-1]}}, i_rdata};
    assign mult_s     = f_ext_s * i_ext_s;
    assign prod_ext_s = PSUM_WIDTH'(prod_r);

    // Next-state, datapath and next-output computation; outputs are registered from these values.
    always_comb begin
        state_s  = state_r;
        s_s      = s_r;
        e_s      = e_r;
        prod_s   = prod_r;
        acc_s    = acc_r;
        done_s   = 1'b0;
        o_data_s = o_data_r;
        o_idx_s  = o_idx_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                    s_s     = S_ZERO;
                    e_s     = E_ZERO;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                prod_s = mult_s;
                // The product registered in the previous RUN cycle is folded in one cycle late.
                if (s_r == S_ZERO) begin
                    acc_s = acc_r;
                end else if (s_r == S_ONE) begin
                    acc_s = prod_ext_s;
                end else begin
                    acc_s = acc_r + prod_ext_s;
                end
                if (s_r == S_LAST) begin
                    state_s = ST_DRAIN;
                end else begin
                    s_s = s_r + S_ONE;
                end
            end
            ST_DRAIN: begin
                if (FILT_LEN == 1) begin
                    acc_s = prod_ext_s;
                end else begin
                    acc_s = acc_r + prod_ext_s;
                end
                state_s  = ST_OUT;
                o_data_s = acc_s;
                o_idx_s  = e_r;
            end
            ST_OUT: begin
                if (o_ready) begin
                    if (e_r == E_LAST) begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        e_s     = e_r + E_ONE;
                        s_s     = S_ZERO;
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (state_s == ST_RUN) begin
            f_raddr_s = s_s;
            i_raddr_s = IA_W'(e_s) + IA_W'(s_s);
        end else begin
            f_raddr_s = FA_W'(0);
            i_raddr_s = IA_W'(0);
        end
        o_valid_s = (state_s == ST_OUT);
        busy_s    = (state_s != ST_IDLE);
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            s_r       <= S_ZERO;
            e_r       <= E_ZERO;
            prod_r    <= '0;
            acc_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            o_valid_r <= 1'b0;
            o_data_r  <= '0;
            o_idx_r   <= '0;
            f_raddr_r <= '0;
            i_raddr_r <= '0;
        end else begin
            state_r   <= state_s;
            s_r       <= s_s;
            e_r       <= e_s;
            prod_r    <= prod_s;
            acc_r     <= acc_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            o_valid_r <= o_valid_s;
            o_data_r  <= o_data_s;
            o_idx_r   <= o_idx_s;
            f_raddr_r <= f_raddr_s;
            i_raddr_r <= i_raddr_s;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign o_valid = o_valid_r;
    assign o_data  = o_data_r;
    assign o_idx   = o_idx_r;
    assign f_raddr = f_raddr_r;
    assign i_raddr = i_raddr_r;

endmodule

// File: tb/tb_pe_conv1d_mac.sv
// Self-checking bench for pe_conv1d_mac: directed vector table, timing corner sequences
// and randomized runs compared against a sum-of-products reference model.
module tb_pe_conv1d_mac;

    localparam int DW = 16;
    localparam int PW = 32;
    localparam int S  = 3;
    localparam int W  = 9;
    localparam int E  = W - S + 1;

    logic          clk = 1'b0;
    logic          rstn, start, busy, done, o_valid, o_ready;
    logic [1:0]    f_raddr;
    logic [3:0]    i_raddr;
    logic [DW-1:0] f_rdata, i_rdata;
    logic [PW-1:0] o_data;
    logic [2:0]    o_idx;

    logic [DW-1:0] fmem [0:3];
    logic [DW-1:0] imem [0:15];
    logic [PW-1:0] exp_a [0:E-1];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [0:S-1][DW-1:0] f;
        logic [0:W-1][DW-1:0] x;
        logic [0:E-1][PW-1:0] y;
    } vec_t;

    vec_t tbl [3];

    assign f_rdata = fmem[f_raddr];
    assign i_rdata = imem[i_raddr];

    always #5 clk = ~clk;

    pe_conv1d_mac #(.DATA_WIDTH(DW), .PSUM_WIDTH(PW), .FILT_LEN(S), .IFMAP_LEN(W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
        .f_raddr(f_raddr), .f_rdata(f_rdata), .i_raddr(i_raddr), .i_rdata(i_rdata),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_idx(o_idx)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [PW-1:0] model(input logic [0:S-1][DW-1:0] f,
                                            input logic [0:W-1][DW-1:0] x, input int e);
        longint acc = 0;
        for (int s = 0; s < S; s++)
            acc += longint'($signed(f[s])) * longint'($signed(x[e+s]));
        return acc[PW-1:0];
    endfunction

    task automatic load(input logic [0:S-1][DW-1:0] f, input logic [0:W-1][DW-1:0] x);
        for (int s = 0; s < S; s++) fmem[s] = f[s];
        for (int i = 0; i < W; i++) imem[i] = x[i];
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
        check({tag, " o_valid"}, 64'(o_valid), 64'd0);
        check({tag, " o_data"}, 64'(o_data), 64'd0);
        check({tag, " o_idx"}, 64'(o_idx), 64'd0);
        check({tag, " f_raddr"}, 64'(f_raddr), 64'd0);
        check({tag, " i_raddr"}, 64'(i_raddr), 64'd0);
    endtask

    // One full run; cycle 0 is the cycle in which start is sampled.
    task automatic do_run(input string tag, input bit pre_started, input int stall_n,
                          input bit rand_bp, input bit poke_start, input bit b2b_next,
                          output int first_v, output int done_c);
        int cyc, nout, stalls;
        bit held;
        logic [PW-1:0] held_d;
        logic [2:0] held_i;
        first_v = -1; done_c = -1; nout = 0; stalls = 0; held = 1'b0;
        held_d = '0; held_i = '0;
        if (!pre_started) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check($sformatf("%s busy in cycle 1", tag), 64'(busy), 64'd1);
        while (done_c < 0 && cyc < 400) begin
            if (poke_start) start = (cyc == 2);
            if (held) begin
                check($sformatf("%s held o_valid c%0d", tag, cyc), 64'(o_valid), 64'd1);
                check($sformatf("%s held o_data c%0d", tag, cyc), 64'(o_data), 64'(held_d));
                check($sformatf("%s held o_idx c%0d", tag, cyc), 64'(o_idx), 64'(held_i));
            end
            if (done) begin
                done_c = cyc;
                check($sformatf("%s busy at done", tag), 64'(busy), 64'd0);
                check($sformatf("%s outputs before done", tag), 64'(nout), 64'(E));
                if (b2b_next) start = 1'b1;
            end else if (o_valid) begin
                if (first_v < 0) first_v = cyc;
                if (nout == 0 && stalls < stall_n) begin
                    o_ready = 1'b0;
                    stalls++;
                end else if (rand_bp) begin
                    o_ready = 1'($urandom_range(0, 1));
                end else begin
                    o_ready = 1'b1;
                end
                held = !o_ready; held_d = o_data; held_i = o_idx;
                if (o_ready) begin
                    if (nout < E)
                        check($sformatf("%s o_data[%0d]", tag, nout), 64'(o_data), 64'(exp_a[nout]));
                    check($sformatf("%s o_idx[%0d]", tag, nout), 64'(o_idx), 64'(nout));
                    nout++;
                end
            end else begin
                held = 1'b0;
                o_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (done_c < 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (done_c < 0) check({tag, " done timeout"}, 64'd0, 64'd1);
        o_ready = 1'b1;
    endtask

    initial begin
        int fv, dc, nv;
        logic [0:S-1][DW-1:0] rf;
        logic [0:W-1][DW-1:0] rx;

        tbl[0].f = {16'd1, 16'd2, 16'd3};
        tbl[0].x = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
        tbl[0].y = {32'd14, 32'd20, 32'd26, 32'd32, 32'd38, 32'd44, 32'd50};
        tbl[1].f = {16'hFFFF, 16'h0000, 16'h0001};
        tbl[1].x = {16'd5, 16'hFFFD, 16'd7, 16'd0, 16'hFFF8, 16'd2, 16'd4, 16'd4, 16'hFFFF};
        tbl[1].y = {32'd2, 32'd3, 32'hFFFFFFF1, 32'd2, 32'd12, 32'd2, 32'hFFFFFFFB};
        tbl[2].f = {S{16'h8000}};
        tbl[2].x = {W{16'h8000}};
        tbl[2].y = {E{32'hC0000000}};

        for (int i = 0; i < 4; i++) fmem[i] = '0;
        for (int i = 0; i < 16; i++) imem[i] = '0;
        rstn = 1'b0; start = 1'b0; o_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rstn = 1'b1;

        for (int v = 0; v < 3; v++) begin
            load(tbl[v].f, tbl[v].x);
            for (int e = 0; e < E; e++) exp_a[e] = tbl[v].y[e];
            do_run($sformatf("vec%0d", v), 1'b0, 0, 1'b0, 1'b0, 1'b0, fv, dc);
            check($sformatf("vec%0d first o_valid cycle", v), 64'(fv), 64'd5);
            check($sformatf("vec%0d done cycle", v), 64'(dc), 64'd36);
            @(negedge clk);
            check($sformatf("vec%0d done single pulse", v), 64'(done), 64'd0);
        end

        load(tbl[0].f, tbl[0].x);
        for (int e = 0; e < E; e++) exp_a[e] = tbl[0].y[e];
        do_run("bp", 1'b0, 4, 1'b0, 1'b0, 1'b0, fv, dc);
        check("bp done cycle", 64'(dc), 64'd40);

        do_run("ignore", 1'b0, 0, 1'b0, 1'b1, 1'b1, fv, dc);
        check("ignore done cycle", 64'(dc), 64'd36);
        do_run("b2b", 1'b1, 0, 1'b0, 1'b0, 1'b0, fv, dc);
        check("b2b first o_valid cycle", 64'(fv), 64'd5);
        check("b2b done cycle", 64'(dc), 64'd36);

        // Reset during DRAIN of e=2 (cycle 14), then a fresh run.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        check("rst pre busy", 64'(busy), 64'd1);
        check("rst pre o_valid", 64'(o_valid), 64'd0);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check_reset_vals("rst mid-op");
        nv = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_valid) nv++;
        end
        check("rst no o_valid after", 64'(nv), 64'd0);
        check("rst idle busy", 64'(busy), 64'd0);
        do_run("post-rst", 1'b0, 0, 1'b0, 1'b0, 1'b0, fv, dc);
        check("post-rst done cycle", 64'(dc), 64'd36);

        for (int r = 0; r < 20; r++) begin
            for (int s = 0; s < S; s++)
                rf[s] = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
            for (int i = 0; i < W; i++)
                rx[i] = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
            load(rf, rx);
            for (int e = 0; e < E; e++) exp_a[e] = model(rf, rx, e);
            do_run($sformatf("rand%0d", r), 1'b0, 0, 1'b1, 1'b0, 1'b0, fv, dc);
            check($sformatf("rand%0d first o_valid cycle", r), 64'(fv), 64'd5);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
